encoder8x3_queued: RTL and testbench
====================================

Name: encoder8x3_queued

Overview:
- Sequential 8-to-3 encoder, the companion of the 3-to-8 decoder.
- Captures one-cycle request pulses on 8 lines into a pending register and emits one 3-bit index per transfer on a valid/ready output.
- Simultaneous requests are serialized in fixed priority order.
- Feeds the decoder's in/enable path, or any consumer of an indexed event stream.

Parameters:
- MSB_FIRST, 1: priority order. 1 = line 7 highest, line 0 lowest; 0 = line 0 highest.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  capture enable. 0 = incoming requests ignored; pending bits and output handshake continue.
- req  input  8  request pulses, one bit per line, sampled each clock.
- out_code  output  3  encoded index of the granted line.
- out_valid  output  1  out_code holds a valid index.
- out_ready  input  1  consumer accepts out_code when out_valid && out_ready.
- pending  output  8  current pending register, registered.
- busy  output  1  (pending != 0) || out_valid.
- drop_cnt  output  CNT_W  number of requests lost to an already-pending bit; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n=0): pending=0, out_code=3'b000, out_valid=0, drop_cnt=0, busy=0. Reset is effective immediately, mid-transfer included. The in-flight code is discarded; no output on release.
- Capture (every rising edge, enable=1): pending_next = (pending & ~clr) | req.
  - clr is the one-hot of the line loaded into the output this cycle, else 0.
  - A set on a line being cleared in the same cycle wins: the line stays pending and is not counted as a drop.
- Drop: for each bit with enable=1, req[i]=1, pending[i]=1 and not cleared this cycle, drop_cnt increments by one per such bit, summed across bits in one cycle. drop_cnt saturates, never wraps.
- Load condition: load = (!out_valid || (out_valid && out_ready)) && (pending != 0).
  - On load: out_code <= index of the highest-priority set bit of the registered pending (per MSB_FIRST), out_valid <= 1, that bit is cleared.
  - Selection uses the registered pending only. Same-cycle req is never granted.
- Accept without load: out_valid && out_ready && pending == 0 -> out_valid <= 0; out_code holds its last value.
- Stall: out_valid && !out_ready -> out_code and out_valid hold unchanged; capture continues.
- Latency: req pulse at edge k sets pending at k; earliest out_valid at edge k+1 (2 cycles req-to-valid).
- Throughput: one code per cycle with out_ready held high and back-to-back pending bits.
- enable=0: req ignored entirely, including for drop counting. Drain of pending is unaffected.
- Pending-order rule: a lower-priority pending line waits while higher-priority lines keep re-arriving. No fairness is guaranteed; starvation is allowed by design.
- Unused code values: none. All 8 codes are legal.

Test Plan:
- Reset, enable=1, out_ready=1, single pulse req=8'b0000_0100 -> pending=8'h04 after 1 edge, then out_code=3'b010 with out_valid=1 one edge later, then out_valid=0 and busy=0.
- Simultaneous pulse req=8'b1000_0011, out_ready=1, MSB_FIRST=1 -> out_code sequence 7, 1, 0 on three consecutive cycles, then out_valid=0. With MSB_FIRST=0 the sequence is 0, 1, 7.
- Backpressure:
  - req=8'h0A, out_ready=0 for 5 cycles -> out_code=3 stays valid and stable; pending=8'h02.
  - Raise out_ready -> codes 3 then 1.
- Drops:
  - out_ready=0, pulse req=8'h01 three times on separate cycles -> first loads the output.
  - Second sets pending[0]; third increments drop_cnt to 1.
  - Repeating 300 such pulses with CNT_W=8 -> drop_cnt saturates at 255.
- Gating and set-wins: enable=0 with req=8'hFF -> pending stays 8'h00, drop_cnt unchanged. Then enable=1, pending[5] granted while req[5] pulses the same cycle -> pending[5] remains 1, out_code=5 emitted twice, drop_cnt unchanged.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 and pending=8'hF0 -> all outputs zero immediately. After release, no code emitted until a new req.

Source files
------------

// File: rtl/encoder8x3_queued.sv
// encoder8x3_queued: captures one-cycle request pulses on 8 lines into a
// pending register and emits one 3-bit line index per valid/ready transfer.
// Simultaneous requests are serialized in fixed priority order (MSB_FIRST).
module encoder8x3_queued #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       req,
  output logic [2:0]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       pending,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       pending_reg, pending_next;
  logic [2:0]       out_code_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic [2:0]       sel_idx;
  logic             load;
  logic [7:0]       clr;
  logic [7:0]       drop_bits;
  logic [3:0]       drop_sum;
  logic [CNT_W+3:0] drop_wide;

  // Highest-priority set bit of the registered pending; later hits overwrite
  // earlier ones, so the scan order puts the top-priority line last.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (MSB_FIRST) begin
        if (pending_reg[i]) sel_idx = 3'(i);
      end else begin
        if (pending_reg[7-i]) sel_idx = 3'(7 - i);
      end
    end
  end

  // Output register is free when empty or being accepted this cycle.
  assign load = (!out_valid_reg || out_ready) && (pending_reg != 8'h00);

  // Per-line clear of the granted bit and detection of lost requests.
  // A request on the line being cleared is kept, not dropped.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      assign clr[gi]       = load && (sel_idx == 3'(gi));
      assign drop_bits[gi] = enable && req[gi] && pending_reg[gi] && !clr[gi];
    end
  endgenerate

  // Next pending image: clear granted line, then OR in captured requests.
  always_comb begin
    pending_next = pending_reg & ~clr;
    if (enable) pending_next = pending_next | req;
  end

  // Sum drops across lines and add with saturation at all-ones.
  always_comb begin
    drop_sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      drop_sum = drop_sum + {3'b000, drop_bits[i]};
    end
    drop_wide = {4'b0000, drop_cnt_reg} + {{CNT_W{1'b0}}, drop_sum};
    if (drop_wide > {4'b0000, CNT_MAX}) drop_cnt_next = CNT_MAX;
    else                                drop_cnt_next = drop_wide[CNT_W-1:0];
  end

  // Pending register and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= 8'h00;
      drop_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Output stage: load a new code, retire an accepted one, or hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_code_reg  <= 3'b000;
      out_valid_reg <= 1'b0;
    end else if (load) begin
      out_code_reg  <= sel_idx;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_code  = out_code_reg;
  assign out_valid = out_valid_reg;
  assign pending   = pending_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign busy      = (pending_reg != 8'h00) || out_valid_reg;

endmodule

// File: tb/tb_encoder8x3_queued.sv
// Bench for encoder8x3_queued: two instances (MSB-first and LSB-first) share
// stimulus and are compared every cycle against a line-by-line reference model.
module tb_encoder8x3_queued;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       out_ready;

  logic [2:0] code1, code0;
  logic       valid1, valid0;
  logic [7:0] pend1, pend0;
  logic       busy1, busy0;
  logic [7:0] drop1, drop0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, index 1 = MSB-first instance, 0 = LSB-first instance.
  logic [7:0] m_pend  [2];
  int         m_code  [2];
  bit         m_valid [2];
  int         m_drop  [2];

  always #5 clk = ~clk;

  encoder8x3_queued #(.MSB_FIRST(1'b1), .CNT_W(8)) dut_msb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .out_code(code1), .out_valid(valid1), .out_ready(out_ready),
    .pending(pend1), .busy(busy1), .drop_cnt(drop1)
  );

  encoder8x3_queued #(.MSB_FIRST(1'b0), .CNT_W(8)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .out_code(code0), .out_valid(valid0), .out_ready(out_ready),
    .pending(pend0), .busy(busy0), .drop_cnt(drop0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 8'h00; m_code[d] = 0; m_valid[d] = 1'b0; m_drop[d] = 0;
    end
  endfunction

  // One clock edge of the behavioural model, using inputs present at the edge.
  function automatic void model_step(input logic [7:0] r, input logic e, input logic rdy);
    for (int d = 0; d < 2; d++) begin
      int pick = -1;
      logic [7:0] np;
      if (m_valid[d] && rdy && d == 1)
        $display("xfer code=%0d", m_code[d]);
      if (!m_valid[d] || rdy) begin
        for (int k = 0; k < 8; k++) begin
          int line = (d == 1) ? 7 - k : k;
          if (pick < 0 && m_pend[d][line]) pick = line;
        end
      end
      np = 8'h00;
      for (int i = 0; i < 8; i++) begin
        bit keep = m_pend[d][i] && (i != pick);
        if (e && r[i]) begin
          if (keep) m_drop[d] = m_drop[d] + 1;
          np[i] = 1'b1;
        end else begin
          np[i] = keep;
        end
      end
      if (m_drop[d] > 255) m_drop[d] = 255;
      m_pend[d] = np;
      if (pick >= 0) begin
        m_code[d] = pick; m_valid[d] = 1'b1;
      end else if (m_valid[d] && rdy) begin
        m_valid[d] = 1'b0;
      end
    end
  endfunction

  task automatic compare_all();
    check("msb.pending", pend1, m_pend[1]);
    check("msb.valid", valid1, m_valid[1]);
    check("msb.code", code1, m_code[1]);
    check("msb.busy", busy1, (m_pend[1] != 0) || m_valid[1]);
    check("msb.drop", drop1, m_drop[1]);
    check("lsb.pending", pend0, m_pend[0]);
    check("lsb.valid", valid0, m_valid[0]);
    check("lsb.code", code0, m_code[0]);
    check("lsb.busy", busy0, (m_pend[0] != 0) || m_valid[0]);
    check("lsb.drop", drop0, m_drop[0]);
  endtask

  task automatic cycle(input logic [7:0] r, input logic e, input logic rdy);
    req = r; enable = e; out_ready = rdy;
    @(posedge clk);
    model_step(r, e, rdy);
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".pending"}, pend1 | pend0, 8'h00);
    check({tag, ".valid"}, valid1 | valid0, 1'b0);
    check({tag, ".code"}, code1 | code0, 3'b000);
    check({tag, ".busy"}, busy1 | busy0, 1'b0);
    check({tag, ".drop"}, drop1 | drop0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; req = 8'h00; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse on line 2.
    cycle(8'h04, 1'b1, 1'b1);
    check("single.pending", pend1, 8'h04);
    cycle(8'h00, 1'b1, 1'b1);
    check("single.code", {valid1, code1}, {1'b1, 3'd2});
    cycle(8'h00, 1'b1, 1'b1);
    check("single.idle", {valid1, busy1}, 2'b00);

    // Simultaneous pulse: 7,1,0 for MSB-first and 0,1,7 for LSB-first.
    cycle(8'h83, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    check("multi.first", {code1, code0}, {3'd7, 3'd0});
    cycle(8'h00, 1'b1, 1'b1);
    check("multi.second", {code1, code0}, {3'd1, 3'd1});
    cycle(8'h00, 1'b1, 1'b1);
    check("multi.third", {code1, code0}, {3'd0, 3'd7});
    cycle(8'h00, 1'b1, 1'b1);
    check("multi.done", {valid1, valid0}, 2'b00);

    // Backpressure.
    cycle(8'h0A, 1'b1, 1'b0);
    repeat (5) cycle(8'h00, 1'b1, 1'b0);
    check("stall.code", {valid1, code1}, {1'b1, 3'd3});
    check("stall.pending", pend1, 8'h02);
    repeat (3) cycle(8'h00, 1'b1, 1'b1);

    // Gating, then set-wins on line 5.
    repeat (2) cycle(8'hFF, 1'b0, 1'b1);
    check("gate.pending", pend1, 8'h00);
    check("gate.drop", drop1, 8'h00);
    cycle(8'h20, 1'b1, 1'b0);
    cycle(8'h20, 1'b1, 1'b0);
    check("setwins.pending", pend1, 8'h20);
    check("setwins.drop", drop1, 8'h00);
    repeat (3) cycle(8'h00, 1'b1, 1'b1);

    // Drops and saturation.
    cycle(8'h01, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h01, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h01, 1'b1, 1'b0);
    check("drop.one", drop1, 8'd1);
    repeat (300) cycle(8'h01, 1'b1, 1'b0);
    check("drop.sat", drop1, 8'd255);
    repeat (3) cycle(8'h00, 1'b1, 1'b1);

    // Async reset mid-stream with valid output and pending=F0.
    cycle(8'hF0, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h80, 1'b1, 1'b0);
    check("midrst.pre", {valid1, pend1}, {1'b1, 8'hF0});
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(8'h00, 1'b1, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cycle(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0));
    end
    repeat (12) cycle(8'h00, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
